// File: rtl/floor_request_dispatcher_if.sv
// Call-button / elevator-controller bundle seen by the floor request dispatcher.
// master: the dispatcher itself. slave: the environment (buttons + controller).
interface floor_request_dispatcher_if;
  logic [3:0] btn_call;
  logic [1:0] cur_floor;
  logic       door_open;
  logic [1:0] req_floor;
  logic       req_valid;
  logic [3:0] pending;
  logic       fault;

  modport master (
    input  btn_call, cur_floor, door_open,
    output req_floor, req_valid, pending, fault
  );

  modport slave (
    output btn_call, cur_floor, door_open,
    input  req_floor, req_valid, pending, fault
  );
endinterface

// File: rtl/floor_request_dispatcher.sv
// Floor request dispatcher: debounces 4 call buttons into latched requests and
// hands them one at a time to the elevator controller in SCAN order.
// Optional WAIT_ARRIVE watchdog enabled by defining DISPATCH_TIMEOUT_EN.

// One call-button lane: 2-FF synchronizer plus saturating debounce counter.
// press pulses for one cycle when a stable-high run reaches DEBOUNCE_CYCLES.
module floor_btn_lane #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ARM = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // synchronize, then count stable-high cycles; any low sample restarts the run
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '0;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], btn};
      if (!sync[1])            cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end
  end

  // fires on the edge the count reaches the limit; saturation blocks re-trigger
  assign press = sync[1] && (cnt == CNT_ARM);
endmodule

module floor_request_dispatcher #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  floor_request_dispatcher_if.master  bus
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, DISPATCH, WAIT_ARRIVE, WAIT_CLOSE} state_t;

  state_t               state, state_nxt;
  logic [NUM_LANES-1:0] press, clr;
  logic [NUM_LANES-1:0] pending, pending_nxt;
  logic [1:0]           req_floor, req_floor_nxt;
  logic                 req_valid, req_valid_nxt;
  logic                 dir_up, dir_up_nxt;
  logic [1:0]           target;
  logic                 target_up;
  logic [NUM_LANES-1:0] above_eq, below, above, below_eq;
  logic                 arrived;

  // per-floor input conditioning
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    floor_btn_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .clk   (clk),
      .reset (reset),
      .btn   (bus.btn_call[i]),
      .press (press[i])
    );
  end

  function automatic logic [1:0] lowest(input logic [NUM_LANES-1:0] v);
    lowest = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) if (v[i]) lowest = 2'(i);
  endfunction

  function automatic logic [1:0] highest(input logic [NUM_LANES-1:0] v);
    highest = '0;
    for (int i = 0; i < NUM_LANES; i++) if (v[i]) highest = 2'(i);
  endfunction

  // SCAN target: keep direction while requests lie ahead, otherwise reverse
  always_comb begin
    above_eq  = pending & (4'b1111 << bus.cur_floor);
    below     = pending & ~above_eq;
    above     = pending & (4'b1110 << bus.cur_floor);
    below_eq  = pending & ~above;
    target    = '0;
    target_up = dir_up;
    if (dir_up) begin
      if (|above_eq) target = lowest(above_eq);
      else begin
        target_up = 1'b0;
        target    = highest(below);
      end
    end else begin
      if (|below_eq) target = highest(below_eq);
      else begin
        target_up = 1'b1;
        target    = lowest(above);
      end
    end
  end

  assign arrived = (bus.cur_floor == req_floor) && bus.door_open;

`ifdef DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
  logic          timed_out;
  logic          fault, fault_nxt;

  // cycles spent in WAIT_ARRIVE; zero on every entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    wait_cnt <= '0;
    else if (state != WAIT_ARRIVE) wait_cnt <= '0;
    else                           wait_cnt <= wait_cnt + 1'b1;
  end

  assign timed_out = (state == WAIT_ARRIVE) && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  // next state, request register updates and pending retirement
  always_comb begin
    state_nxt     = state;
    req_floor_nxt = req_floor;
    req_valid_nxt = req_valid;
    dir_up_nxt    = dir_up;
    clr           = '0;
`ifdef DISPATCH_TIMEOUT_EN
    fault_nxt     = 1'b0;
`endif
    case (state)
      IDLE:        if (|pending) state_nxt = DISPATCH;
      DISPATCH: begin
        req_floor_nxt = target;
        dir_up_nxt    = target_up;
        req_valid_nxt = 1'b1;
        state_nxt     = WAIT_ARRIVE;
      end
      WAIT_ARRIVE: begin
        // arrival beats a coincident timeout: the request was served
        if (arrived) begin
          clr[req_floor] = 1'b1;
          req_valid_nxt  = 1'b0;
          state_nxt      = WAIT_CLOSE;
        end
`ifdef DISPATCH_TIMEOUT_EN
        else if (timed_out) begin
          clr[req_floor] = 1'b1;
          req_valid_nxt  = 1'b0;
          fault_nxt      = 1'b1;
          state_nxt      = IDLE;
        end
`endif
      end
      WAIT_CLOSE:  if (!bus.door_open) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
    // a press landing on the retire cycle is dropped
    pending_nxt = (pending | press) & ~clr;
  end

  // registered state and outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pending   <= '0;
      req_floor <= '0;
      req_valid <= 1'b0;
      dir_up    <= 1'b1;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      req_floor <= req_floor_nxt;
      req_valid <= req_valid_nxt;
      dir_up    <= dir_up_nxt;
    end
  end

`ifdef DISPATCH_TIMEOUT_EN
  // one-cycle watchdog pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fault <= 1'b0;
    else        fault <= fault_nxt;
  end
  assign bus.fault = fault;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign bus.fault      = 1'b0;
`endif

  assign bus.pending   = pending;
  assign bus.req_floor = req_floor;
  assign bus.req_valid = req_valid;
endmodule
